// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
package tow_pkg;

  // Computer player control states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    PRESS    = 2'd2,
    COOLDOWN = 2'd3
  } cp_state_t;

  // Feedback taps for x^10 + x^7 + 1. The new bit0 is q[9] ^ q[6].
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR that steps once per advance pulse.
// An all-zero state would never leave zero, so the next advance reloads SEED instead.
module lfsr_gen
  import tow_pkg::*;
#(
  parameter int                LFSR_W = 10,
  parameter logic [LFSR_W-1:0] SEED   = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] w_q_next;
  logic              w_feedback;

  // Next LFSR value: hold, shift with feedback, or recover from the zero lockup.
  always_comb begin
    w_q_next   = r_q;
    w_feedback = r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO];
    if (advance) begin
      if (r_q == {LFSR_W{1'b0}}) begin
        w_q_next = SEED;
      end else begin
        w_q_next = {r_q[LFSR_W-2:0], w_feedback};
      end
    end else begin
      w_q_next = r_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= SEED;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/computer_player.sv
// Automated tug-of-war opponent. It emits single-cycle press pulses at a rate
// set by the difficulty threshold, which is compared against a free-running LFSR
// on every decision tick.
module computer_player
  import tow_pkg::*;
#(
  parameter int                LFSR_W    = 10,
  parameter int                TICK_DIV  = 5000,
  parameter int                GAP_TICKS = 2,
  parameter logic [LFSR_W-1:0] SEED      = 10'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_next;
  cp_state_t         r_state;
  cp_state_t         w_state_next;
  logic              r_press;
  logic              w_tick;
  logic              w_hit;
  logic [LFSR_W-1:0] w_lfsr;

  assign w_tick = (r_div_cnt == DIV_LAST);
  // The LFSR value seen here is the one before this tick's shift.
  assign w_hit  = (difficulty > w_lfsr);

  // Decision-tick prescaler, free running whether or not a round is in play.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (w_tick) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (w_tick),
    .q       (w_lfsr)
  );

  // Next-state and cooldown counter logic; dropping enable always wins.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = WAIT;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if (w_tick && w_hit) begin
          w_state_next = PRESS;
        end else begin
          w_state_next = WAIT;
        end
      end
      PRESS: begin
        w_gap_next = GAP_LOAD;
        if (!enable) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          w_gap_next = r_gap_cnt - GAP_ONE;
          if (r_gap_cnt == GAP_ONE) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = COOLDOWN;
          end
        end else begin
          w_state_next = COOLDOWN;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gap_next   = {GAP_W{1'b0}};
      end
    endcase
  end

  // State, cooldown counter and press output registers.
  // press is registered from the next state so it always equals (state == PRESS).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gap_cnt <= {GAP_W{1'b0}};
      r_press   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_next;
      r_press   <= (w_state_next == PRESS);
    end
  end

  assign press  = r_press;
  assign lfsr_q = w_lfsr;

endmodule

// File: tb/tb_computer_player.sv
// Self-checking bench for computer_player with a fast prescaler.
module tb_computer_player;
  import tow_pkg::*;

  localparam int TDIV = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] diff;
  logic       press;
  logic [9:0] lfsr_q;

  computer_player #(
    .LFSR_W    (10),
    .TICK_DIV  (TDIV),
    .GAP_TICKS (GAP),
    .SEED      (10'h001)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (en),
    .difficulty (diff),
    .press      (press),
    .lfsr_q     (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counters and flags derived from the behavioural rules.
  int  m_div      = 0;
  int  m_lfsr     = 1;
  bit  m_active   = 0;   // round in play (not idle)
  bit  m_press    = 0;   // pulse being emitted this cycle
  int  m_cool     = 0;   // ticks of cooldown left
  bit  m_tick_now = 0;   // last edge was a decision tick
  int  m_eligible = 0;
  bit  prev_press = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  old;
    bit  tick;
    if (rst) begin
      m_div = 0; m_lfsr = 1; m_active = 0; m_press = 0; m_cool = 0; m_tick_now = 0;
    end else begin
      tick = (m_div == TDIV - 1);
      m_tick_now = tick;
      m_div = (m_div + 1) % TDIV;
      old = m_lfsr;
      if (tick) begin
        if (old == 0) m_lfsr = 1;
        else m_lfsr = ((old * 2) % 1024) + (((old / 512) + (old / 64)) % 2);
      end
      if (m_press) begin
        m_press  = 0;
        m_active = en;
        m_cool   = en ? GAP : 0;
      end else if (!en) begin
        m_active = 0;
        m_cool   = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else if (tick) begin
        if (m_cool > 0) begin
          m_cool--;
        end else begin
          m_eligible++;
          if (int'(diff) > old) m_press = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("press", {31'd0, press}, {31'd0, m_press});
    chk("lfsr_q", {22'd0, lfsr_q}, m_lfsr);
    chk("no_adjacent_press", {31'd0, press & prev_press}, 32'd0);
    prev_press = press;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_press(input string nm, input int budget, output int waited);
    waited = 0;
    while (!press && waited < budget) begin
      cyc();
      waited++;
    end
    chk({nm, "_timeout"}, {31'd0, press}, 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] diff;
    logic       exp_press;
    logic [9:0] exp_lfsr;
  } vec_t;

  vec_t tbl[32];

  initial begin
    int w;
    int cnt;
    int last_rise;
    int t;
    logic [9:0] d;
    logic [9:0] l;
    logic       p;

    rst = 1'b1; en = 1'b0; diff = 10'h000;

    // Hand-derived vectors: reset, max difficulty press timing, then zero difficulty.
    for (int i = 0; i < 32; i++) begin
      if (i < 3 || (i >= 20 && i < 23)) begin
        tbl[i] = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h001};
      end else begin
        d = (i < 20) ? 10'h3FF : 10'h000;
        p = (i == 6 || i == 18) ? 1'b1 : 1'b0;
        if (i < 20) begin
          t = i - 3;
          l = 10'h001 << ((t + 1) / 4);
        end else begin
          t = i - 23;
          l = 10'h001 << ((t + 1) / 4);
        end
        tbl[i] = '{1'b0, 1'b1, d, p, l};
      end
    end

    for (int i = 0; i < 32; i++) begin
      rst  = tbl[i].rst;
      en   = tbl[i].en;
      diff = tbl[i].diff;
      cyc();
      chk($sformatf("tbl%0d_press", i), {31'd0, press}, {31'd0, tbl[i].exp_press});
      chk($sformatf("tbl%0d_lfsr", i), {22'd0, lfsr_q}, {22'd0, tbl[i].exp_lfsr});
    end

    // Zero difficulty never presses while the LFSR keeps stepping.
    en = 1'b0; diff = 10'h000;
    do_reset(3);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (press) cnt++;
    end
    chk("diff0_press_count", cnt, 32'd0);

    // Max difficulty: press rises every (GAP+1)*TDIV cycles.
    en = 1'b0; diff = 10'h3FF;
    do_reset(3);
    en = 1'b1;
    last_rise = -1;
    for (int i = 1; i <= 120; i++) begin
      cyc();
      if (press) begin
        if (last_rise < 0) chk("first_press_latency", i, 32'd4);
        else chk("press_spacing", i - last_rise, (GAP + 1) * TDIV);
        last_rise = i;
      end
    end

    // Half difficulty: press rate against eligible ticks.
    en = 1'b0; diff = 10'h200;
    do_reset(2);
    en = 1'b1;
    m_eligible = 0;
    cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      cyc();
      if (press) cnt++;
    end
    chk("half_rate_low", {31'd0, (cnt * 100 >= m_eligible * 40)}, 32'd1);
    chk("half_rate_high", {31'd0, (cnt * 100 <= m_eligible * 60)}, 32'd1);

    // Enable dropped during the press cycle.
    en = 1'b0; diff = 10'h3FF;
    do_reset(2);
    en = 1'b1;
    wait_press("en_drop", 40, w);
    en = 1'b0;
    cyc();
    chk("en_drop_state", {30'd0, dut.r_state}, {30'd0, IDLE});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (press) cnt++;
    end
    chk("en_low_no_press", cnt, 32'd0);
    en = 1'b1;
    cyc();
    chk("en_resume_state", {30'd0, dut.r_state}, {30'd0, WAIT});
    wait_press("en_resume", 40, w);

    // Reset during cooldown.
    en = 1'b0; diff = 10'h3FF;
    do_reset(2);
    en = 1'b1;
    wait_press("cool_rst", 40, w);
    cyc();
    cyc();
    chk("in_cooldown", {30'd0, dut.r_state}, {30'd0, COOLDOWN});
    rst = 1'b1;
    cyc();
    chk("cool_rst_press", {31'd0, press}, 32'd0);
    chk("cool_rst_lfsr", {22'd0, lfsr_q}, 32'h001);
    rst = 1'b0;
    wait_press("after_rst", 40, w);
    chk("after_rst_latency", w, 32'd4);

    // Zero-state lockup guard.
    en = 1'b0; diff = 10'h000;
    do_reset(2);
    en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    while (m_div == TDIV - 1) cyc();
    force dut.u_lfsr.r_q = 10'h000;
    #1;
    release dut.u_lfsr.r_q;
    m_lfsr = 0;
    chk("lfsr_forced_zero", {22'd0, lfsr_q}, 32'h000);
    w = 0;
    m_tick_now = 0;
    while (!m_tick_now && w < 2 * TDIV) begin
      cyc();
      w++;
    end
    chk("lockup_recover", {22'd0, lfsr_q}, 32'h001);
    chk("lockup_no_press", {31'd0, press}, 32'd0);

    // Randomised traffic against the model.
    en = 1'b1; diff = 10'($urandom);
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) diff = 10'($urandom);
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
